// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT/IFFT blocks: FSM states, Q8 twiddles, bit reversal.
package fft_pkg;

  // Twiddle constants are Q8 fixed point carried in 16-bit signed words.
  localparam int TW_FRAC  = 8;
  localparam int TW_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Conjugate twiddles W^m = e^{+j*2*pi*m/8}, m = 0..3.
  // The forward transform negates the imaginary parts locally.
  localparam logic signed [TW_WIDTH-1:0] W0_RE = 16'sh0100;
  localparam logic signed [TW_WIDTH-1:0] W0_IM = 16'sh0000;
  localparam logic signed [TW_WIDTH-1:0] W1_RE = 16'sh00B5;
  localparam logic signed [TW_WIDTH-1:0] W1_IM = 16'sh00B5;
  localparam logic signed [TW_WIDTH-1:0] W2_RE = 16'sh0000;
  localparam logic signed [TW_WIDTH-1:0] W2_IM = 16'sh0100;
  localparam logic signed [TW_WIDTH-1:0] W3_RE = -16'sh00B5;
  localparam logic signed [TW_WIDTH-1:0] W3_IM = 16'sh00B5;

  function automatic logic signed [TW_WIDTH-1:0] tw_re(input logic [1:0] m);
    case (m)
      2'd0:    return W0_RE;
      2'd1:    return W1_RE;
      2'd2:    return W2_RE;
      default: return W3_RE;
    endcase
  endfunction

  function automatic logic signed [TW_WIDTH-1:0] tw_im(input logic [1:0] m);
    case (m)
      2'd0:    return W0_IM;
      2'd1:    return W1_IM;
      2'd2:    return W2_IM;
      default: return W3_IM;
    endcase
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 butterfly with twiddle multiply and a built-in halving of both outputs.
module ifft_bfly
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a_re_i,
  input  logic signed [DATA_WIDTH-1:0] a_im_i,
  input  logic signed [DATA_WIDTH-1:0] b_re_i,
  input  logic signed [DATA_WIDTH-1:0] b_im_i,
  input  logic signed [TW_WIDTH-1:0]   w_re_i,
  input  logic signed [TW_WIDTH-1:0]   w_im_i,
  output logic signed [DATA_WIDTH-1:0] y0_re_o,
  output logic signed [DATA_WIDTH-1:0] y0_im_o,
  output logic signed [DATA_WIDTH-1:0] y1_re_o,
  output logic signed [DATA_WIDTH-1:0] y1_im_o
);

  // Full-precision complex product, then the sum/difference one bit wider than the data.
  localparam int PW = DATA_WIDTH + TW_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 1;

  logic signed [PW-1:0] t_re_full, t_im_full;
  logic signed [SW-1:0] t_re, t_im, a_re_x, a_im_x;
  logic signed [SW-1:0] s0_re, s0_im, s1_re, s1_im;

  assign t_re_full = PW'(b_re_i) * PW'(w_re_i) - PW'(b_im_i) * PW'(w_im_i);
  assign t_im_full = PW'(b_re_i) * PW'(w_im_i) + PW'(b_im_i) * PW'(w_re_i);

  // Drop the Q8 fraction with floor rounding, keep DATA_WIDTH+1 bits (wraps on overflow).
  assign t_re = SW'(t_re_full >>> TW_FRAC);
  assign t_im = SW'(t_im_full >>> TW_FRAC);

  assign a_re_x = SW'(a_re_i);
  assign a_im_x = SW'(a_im_i);

  assign s0_re = a_re_x + t_re;
  assign s0_im = a_im_x + t_im;
  assign s1_re = a_re_x - t_re;
  assign s1_im = a_im_x - t_im;

  // Halving per pass gives the overall 1/8 scaling after three passes.
  assign y0_re_o = DATA_WIDTH'(s0_re >>> 1);
  assign y0_im_o = DATA_WIDTH'(s0_im >>> 1);
  assign y1_re_o = DATA_WIDTH'(s1_re >>> 1);
  assign y1_im_o = DATA_WIDTH'(s1_im >>> 1);

endmodule

// File: rtl/ifft_8p_stream.sv
// Streaming 8-point inverse FFT: load a bit-reversed frame, run three in-place passes, drain in order.
module ifft_8p_stream
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic signed [DATA_WIDTH-1:0] in_real_i,
  input  logic signed [DATA_WIDTH-1:0] in_imag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic signed [DATA_WIDTH-1:0] out_real_o,
  output logic signed [DATA_WIDTH-1:0] out_imag_o,
  output logic [2:0]                   out_index_o,
  output logic                         out_last_o
);

  state_e     state_q;
  logic [2:0] load_cnt_q, out_idx_q;
  logic [1:0] pass_q;
  logic       in_ready_q, out_valid_q;
  logic       in_fire, out_fire;

  logic signed [DATA_WIDTH-1:0] bank_re_q [8];
  logic signed [DATA_WIDTH-1:0] bank_im_q [8];
  logic signed [DATA_WIDTH-1:0] bank_re_d [8];
  logic signed [DATA_WIDTH-1:0] bank_im_d [8];

  logic [2:0] a_idx [4];
  logic [2:0] b_idx [4];
  logic [1:0] tw_sel [4];
  logic signed [DATA_WIDTH-1:0] y0_re [4];
  logic signed [DATA_WIDTH-1:0] y0_im [4];
  logic signed [DATA_WIDTH-1:0] y1_re [4];
  logic signed [DATA_WIDTH-1:0] y1_im [4];

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // Pair and twiddle selection for each of the four butterflies, by pass (span 1, 2, 4).
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      a_idx[b]  = '0;
      b_idx[b]  = '0;
      tw_sel[b] = '0;
      case (pass_q)
        2'd0: begin
          a_idx[b]  = 3'(2 * b);
          b_idx[b]  = 3'(2 * b + 1);
          tw_sel[b] = 2'd0;
        end
        2'd1: begin
          a_idx[b]  = 3'((b / 2) * 4 + (b % 2));
          b_idx[b]  = 3'((b / 2) * 4 + (b % 2) + 2);
          tw_sel[b] = 2'((b % 2) * 2);
        end
        default: begin
          a_idx[b]  = 3'(b);
          b_idx[b]  = 3'(b + 4);
          tw_sel[b] = 2'(b);
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_bfly
    ifft_bfly #(.DATA_WIDTH(DATA_WIDTH)) u_bfly (
      .a_re_i (bank_re_q[a_idx[gi]]),
      .a_im_i (bank_im_q[a_idx[gi]]),
      .b_re_i (bank_re_q[b_idx[gi]]),
      .b_im_i (bank_im_q[b_idx[gi]]),
      .w_re_i (tw_re(tw_sel[gi])),
      .w_im_i (tw_im(tw_sel[gi])),
      .y0_re_o(y0_re[gi]),
      .y0_im_o(y0_im[gi]),
      .y1_re_o(y1_re[gi]),
      .y1_im_o(y1_im[gi])
    );
  end

  // Bank next state: bit-reversed write while loading, full in-place pass while calculating.
  always_comb begin
    bank_re_d = bank_re_q;
    bank_im_d = bank_im_q;
    if (state_q == ST_LOAD && in_fire) begin
      bank_re_d[bitrev3(load_cnt_q)] = in_real_i;
      bank_im_d[bitrev3(load_cnt_q)] = in_imag_i;
    end else if (state_q == ST_CALC) begin
      for (int b = 0; b < 4; b++) begin
        bank_re_d[a_idx[b]] = y0_re[b];
        bank_im_d[a_idx[b]] = y0_im[b];
        bank_re_d[b_idx[b]] = y1_re[b];
        bank_im_d[b_idx[b]] = y1_im[b];
      end
    end
  end

  // Complex register bank, cleared on reset so a partial frame is discarded.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < 8; i++) begin
        bank_re_q[i] <= '0;
        bank_im_q[i] <= '0;
      end
    end else begin
      bank_re_q <= bank_re_d;
      bank_im_q <= bank_im_d;
    end
  end

  // Frame sequencer LOAD -> CALC -> DRAIN with registered handshake outputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      pass_q      <= '0;
      out_idx_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_fire) begin
            load_cnt_q <= load_cnt_q + 3'd1;
            if (load_cnt_q == 3'(N - 1)) begin
              state_q    <= ST_CALC;
              pass_q     <= '0;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          pass_q <= pass_q + 2'd1;
          if (pass_q == 2'd2) begin
            state_q     <= ST_DRAIN;
            pass_q      <= '0;
            out_valid_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (out_idx_q == 3'(N - 1)) begin
              state_q     <= ST_LOAD;
              out_idx_q   <= '0;
              load_cnt_q  <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              out_idx_q <= out_idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q     <= ST_LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_index_o = out_idx_q;
  assign out_real_o  = bank_re_q[out_idx_q];
  assign out_imag_o  = bank_im_q[out_idx_q];
  assign out_last_o  = out_valid_q && (out_idx_q == 3'(N - 1));

endmodule

// File: tb/tb_ifft_8p_stream.sv
// Self-checking bench for ifft_8p_stream: directed spectra plus random frames against a reference IFFT.
module tb_ifft_8p_stream;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 arst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [2:0]           out_index;
  logic                 out_last;

  int n_checks = 0;
  int n_errors = 0;

  // Frame under test, reference result and captured output.
  int xr [8];
  int xi [8];
  int er [8];
  int ei [8];
  int gr [8];
  int gim [8];

  always #5 clk = ~clk;

  ifft_8p_stream #(.DATA_WIDTH(DW), .N(8)) dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_real_i  (in_re),
    .in_imag_i  (in_im),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_real_o (out_re),
    .out_imag_o (out_im),
    .out_index_o(out_index),
    .out_last_o (out_last)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: textbook iterative radix-2 decimation-in-time IFFT on integers,
  // halving after every stage with floor rounding and Q8 conjugate twiddles.
  task automatic model();
    int br [8];
    int bi [8];
    int twr [4] = '{256, 181, 0, -181};
    int twi [4] = '{0, 181, 256, 181};
    int rev, m, tr, ti, ar, ai, p, q;
    for (int k = 0; k < 8; k++) begin
      rev = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      br[rev] = xr[k];
      bi[rev] = xi[k];
    end
    for (int h = 1; h < 8; h = h * 2) begin
      for (int g = 0; g < 8; g = g + 2 * h) begin
        for (int i = 0; i < h; i++) begin
          m  = i * (4 / h);
          p  = g + i;
          q  = g + i + h;
          tr = (twr[m] * br[q] - twi[m] * bi[q]) >>> 8;
          ti = (twr[m] * bi[q] + twi[m] * br[q]) >>> 8;
          ar = br[p];
          ai = bi[p];
          br[p] = (ar + tr) >>> 1;
          bi[p] = (ai + ti) >>> 1;
          br[q] = (ar - tr) >>> 1;
          bi[q] = (ai - ti) >>> 1;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      er[n] = br[n];
      ei[n] = bi[n];
    end
  endtask

  // Push xr/xi through the DUT and capture the drained frame into gr/gim.
  // gaps: random in_valid bubbles; junk: in_valid high with garbage outside LOAD;
  // bp: out_ready low for 5 cycles after the n = 3 handshake.
  task automatic run_frame(input bit gaps, input bit junk, input bit bp);
    int  k, guard, lat, n, stall;
    bit  beat;
    model();
    k = 0;
    guard = 0;
    @(posedge clk); #1;
    while (k < 8 && guard < 500) begin
      check_eq("load_in_ready", in_ready, 1);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_re = DW'($urandom);
        in_im = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_re = DW'(xr[k]);
        in_im = DW'(xi[k]);
      end
      beat = in_valid && in_ready;
      @(posedge clk); #1;
      if (beat) k++;
      guard++;
    end
    check_eq("load_beats", k, 8);

    in_valid = junk;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check_eq("calc_in_ready", in_ready, 0);
      if (junk) begin
        in_re = DW'($urandom);
        in_im = DW'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, 3);

    n = 0;
    guard = 0;
    stall = 0;
    while (n < 8 && guard < 200) begin
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      if (junk) begin
        in_re = DW'($urandom);
        in_im = DW'($urandom);
      end
      check_eq("drain_valid", out_valid, 1);
      check_eq("drain_in_ready", in_ready, 0);
      check_eq("drain_index", out_index, n);
      check_eq("drain_last", out_last, (n == 7) ? 1 : 0);
      check_eq($sformatf("drain_re%0d", n), out_re, er[n]);
      check_eq($sformatf("drain_im%0d", n), out_im, ei[n]);
      if (out_ready && out_valid) begin
        gr[n]  = out_re;
        gim[n] = out_im;
        $display("frame out n=%0d x=(%0d,%0d) expected (%0d,%0d)", n, out_re, out_im, er[n], ei[n]);
        n++;
        if (bp && n == 4) stall = 5;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'(($urandom_range(0, 1)));
    check_eq("drain_beats", n, 8);
    check_eq("post_in_ready", in_ready, 1);
    check_eq("post_out_valid", out_valid, 0);
  endtask

  task automatic set_impulse();
    for (int k = 0; k < 8; k++) begin
      xr[k] = (k == 0) ? 800 : 0;
      xi[k] = 0;
    end
  endtask

  task automatic check_impulse(input string pfx);
    for (int n = 0; n < 8; n++) begin
      check_eq($sformatf("%s_re%0d", pfx, n), gr[n], 100);
      check_eq($sformatf("%s_im%0d", pfx, n), gim[n], 0);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_in_ready"}, in_ready, 1);
    check_eq({pfx, "_out_valid"}, out_valid, 0);
    check_eq({pfx, "_out_re"}, out_re, 0);
    check_eq({pfx, "_out_im"}, out_im, 0);
    check_eq({pfx, "_out_index"}, out_index, 0);
    check_eq({pfx, "_out_last"}, out_last, 0);
  endtask

  initial begin
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    arst = 1'b0;

    // Impulse at bin 0.
    set_impulse();
    run_frame(1'b0, 1'b0, 1'b0);
    check_impulse("impulse");

    // Flat spectrum concentrates at n = 0.
    for (int k = 0; k < 8; k++) begin
      xr[k] = 80;
      xi[k] = 0;
    end
    run_frame(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      check_eq($sformatf("flat_re%0d", n), gr[n], (n == 0) ? 80 : 0);
      check_eq($sformatf("flat_im%0d", n), gim[n], 0);
    end

    // Single tone at bin 1, with bubbles, junk input and backpressure.
    for (int k = 0; k < 8; k++) begin
      xr[k] = (k == 1) ? 800 : 0;
      xi[k] = 0;
    end
    run_frame(1'b1, 1'b1, 1'b1);
    check_eq("tone_x0_re", gr[0], 100);
    check_eq("tone_x0_im", gim[0], 0);
    check_eq("tone_x1_re_tol", (gr[1] >= 68 && gr[1] <= 72) ? 1 : 0, 1);
    check_eq("tone_x1_im_tol", (gim[1] >= 68 && gim[1] <= 72) ? 1 : 0, 1);
    check_eq("tone_x2_re", gr[2], 0);
    check_eq("tone_x2_im", gim[2], 100);
    check_eq("tone_x4_re", gr[4], -100);
    check_eq("tone_x4_im", gim[4], 0);
    check_eq("tone_x6_re", gr[6], 0);
    check_eq("tone_x6_im", gim[6], -100);

    // Random spectra against the reference model, random stimulus modes.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 8; k++) begin
        xr[k] = $urandom_range(0, 6000) - 3000;
        xi[k] = $urandom_range(0, 6000) - 3000;
      end
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset after 5 input beats discards the partial frame.
    @(posedge clk); #1;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      in_re = DW'($urandom_range(0, 2000));
      in_im = DW'($urandom_range(0, 2000));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    arst = 1'b0;
    set_impulse();
    run_frame(1'b0, 1'b0, 1'b0);
    check_impulse("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
